stall_ctrl: RTL and testbench

STALL_CTRL -- requirements
Module: stall_ctrl

---
 rtl/stall_ctrl_pkg.sv | 22 ++
 rtl/md_busy_counter.sv | 39 +++
 rtl/stall_ctrl.sv | 81 ++++++++
 tb/tb_stall_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stall_ctrl_pkg.sv
// Shared encodings and constants for the pipeline stall controller.
package stall_ctrl_pkg;

  // Tuse/Tnew encoding: cycles until use/availability, TNone = not used.
  typedef enum logic [1:0] {
    T0    = 2'd0,
    T1    = 2'd1,
    T2    = 2'd2,
    TNone = 2'd3
  } t_stage_e;

  localparam int unsigned MD_CNT_W    = 4;
  localparam int unsigned MULT_CYCLES = 5;
  localparam int unsigned DIV_CYCLES  = 10;

  // A read of src at tuse collides with a pending write to dst ready only at tnew.
  function automatic logic raw_hazard(input logic [4:0] src, input logic [4:0] dst,
                                      input logic [1:0] tuse, input logic [1:0] tnew);
    return (src != 5'd0) && (src == dst) && (tuse != TNone) && (tnew > tuse);
  endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Mult/div busy countdown: loads the unit latency on an accepted start, counts to zero.
module md_busy_counter
  import stall_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                is_div,
  output logic                busy,
  output logic [MD_CNT_W-1:0] count
);

  localparam logic [MD_CNT_W-1:0] MultLoad = MD_CNT_W'(MULT_CYCLES);
  localparam logic [MD_CNT_W-1:0] DivLoad  = MD_CNT_W'(DIV_CYCLES);

  logic [MD_CNT_W-1:0] count_d, count_q;

  // A start seen while already counting is dropped, not queued.
  always_comb begin
    count_d = count_q;
    if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end else if (start) begin
      count_d = is_div ? DivLoad : MultLoad;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign busy  = (count_q != '0) | start;
  assign count = count_q;

endmodule

// File: rtl/stall_ctrl.sv
// Hazard/mult-div stall controller. Define STALL_PERF_CNT_EN to add the stall_cycles counter.
module stall_ctrl
  import stall_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs_D,
  input  logic [4:0]  rt_D,
  input  logic [1:0]  tuse_rs,
  input  logic [1:0]  tuse_rt,
  input  logic [4:0]  a3_E,
  input  logic [4:0]  a3_M,
  input  logic [1:0]  tnew_E,
  input  logic [1:0]  tnew_M,
  input  logic        md_start_E,
  input  logic        md_is_div_E,
  input  logic        md_use_D,
  output logic        stall,
  output logic        pc_en,
  output logic        d_en,
  output logic        e_flush,
  output logic        md_busy
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  logic                data_stall;
  logic                md_stall;
  logic                md_busy_w;
  logic [MD_CNT_W-1:0] md_count;
  logic                unused_md_count;

  md_busy_counter u_md_busy_counter (
    .clk   (clk),
    .reset (reset),
    .start (md_start_E),
    .is_div(md_is_div_E),
    .busy  (md_busy_w),
    .count (md_count)
  );

  assign unused_md_count = ^md_count;

  always_comb begin
    data_stall = raw_hazard(rs_D, a3_E, tuse_rs, tnew_E) |
                 raw_hazard(rs_D, a3_M, tuse_rs, tnew_M) |
                 raw_hazard(rt_D, a3_E, tuse_rt, tnew_E) |
                 raw_hazard(rt_D, a3_M, tuse_rt, tnew_M);
    md_stall   = md_use_D & md_busy_w;
    stall      = data_stall | md_stall;
    pc_en      = ~stall;
    d_en       = ~stall;
    e_flush    = stall;
    md_busy    = md_busy_w;
  end

`ifdef STALL_PERF_CNT_EN
  logic [31:0] stall_cycles_d, stall_cycles_q;

  // Free-running; wraps naturally at 2^32.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_stall_ctrl.sv
// Self-checking bench for stall_ctrl: directed scenarios plus random traffic vs a cycle model.
module tb_stall_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs_D, rt_D, a3_E, a3_M;
  logic [1:0] tuse_rs, tuse_rt, tnew_E, tnew_M;
  logic       md_start_E, md_is_div_E, md_use_D;
  logic       stall, pc_en, d_en, e_flush, md_busy;
`ifdef STALL_PERF_CNT_EN
  logic [31:0] stall_cycles;
`endif

  int errors = 0;
  int checks = 0;

  // Model state: current cycle number and last cycle the mult/div unit stays busy.
  int cyc      = 0;
  int busy_end = -1;
`ifdef STALL_PERF_CNT_EN
  int unsigned perf_cnt = 0;
`endif

  always #5 clk = ~clk;

  stall_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .rs_D       (rs_D),
    .rt_D       (rt_D),
    .tuse_rs    (tuse_rs),
    .tuse_rt    (tuse_rt),
    .a3_E       (a3_E),
    .a3_M       (a3_M),
    .tnew_E     (tnew_E),
    .tnew_M     (tnew_M),
    .md_start_E (md_start_E),
    .md_is_div_E(md_is_div_E),
    .md_use_D   (md_use_D),
    .stall      (stall),
    .pc_en      (pc_en),
    .d_en       (d_en),
    .e_flush    (e_flush),
    .md_busy    (md_busy)
`ifdef STALL_PERF_CNT_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  function automatic bit model_data_stall();
    bit s = 0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        int src  = (i == 0) ? int'(rs_D) : int'(rt_D);
        int tu   = (i == 0) ? int'(tuse_rs) : int'(tuse_rt);
        int dst  = (j == 0) ? int'(a3_E) : int'(a3_M);
        int tn   = (j == 0) ? int'(tnew_E) : int'(tnew_M);
        if (src != 0 && src == dst && tu != 3 && tn > tu) s = 1;
      end
    end
    return s;
  endfunction

  function automatic bit model_busy();
    return (cyc <= busy_end) || md_start_E;
  endfunction

  function automatic bit model_stall();
    return model_data_stall() || (md_use_D && model_busy());
  endfunction

  task automatic clear_inputs();
    rs_D = 0; rt_D = 0; a3_E = 0; a3_M = 0;
    tuse_rs = 3; tuse_rt = 3; tnew_E = 0; tnew_M = 0;
    md_start_E = 0; md_is_div_E = 0; md_use_D = 0;
  endtask

  // Advance one clock and update the model with the inputs the DUT sampled.
  task automatic tick();
    bit s;
    s = model_stall();
    @(posedge clk);
    if (reset) begin
      busy_end = cyc;
    end else if (md_start_E && cyc > busy_end) begin
      busy_end = cyc + (md_is_div_E ? 10 : 5);
    end
`ifdef STALL_PERF_CNT_EN
    if (reset) perf_cnt = 0;
    else if (s) perf_cnt = perf_cnt + 1;
`endif
    cyc = cyc + 1;
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #3;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    md_start_E = 1'b1;
    #3;
    checks++;
    if (md_busy !== 1'b1) begin
      errors++; $display("FAIL reset_start_busy: md_busy=%b expected 1", md_busy);
    end
    tick();
    md_start_E = 1'b0;
    tick();
    reset = 1'b0;
    #3;
    checks++;
    if (md_busy !== 1'b0 || stall !== 1'b0 || pc_en !== 1'b1 || d_en !== 1'b1 ||
        e_flush !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b stall=%b pc_en=%b d_en=%b e_flush=%b expected 0 0 1 1 0",
               md_busy, stall, pc_en, d_en, e_flush);
    end
  endtask

  task automatic test_data_hazard();
    do_reset();
    rs_D = 8; tuse_rs = 0; a3_E = 8; tnew_E = 1;
    #3;
    checks++;
    if (stall !== 1'b1 || pc_en !== 1'b0 || d_en !== 1'b0 || e_flush !== 1'b1) begin
      errors++;
      $display("FAIL rs_E_hazard: stall=%b pc_en=%b d_en=%b e_flush=%b expected 1 0 0 1",
               stall, pc_en, d_en, e_flush);
    end
    a3_E = 0;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL rs_E_cleared: stall=%b expected 0", stall);
    end
    clear_inputs();
    rt_D = 0; a3_M = 0; tnew_M = 2; tuse_rt = 0;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL zero_reg: stall=%b expected 0", stall);
    end
    rt_D = 17; a3_M = 17; tnew_M = 2; tuse_rt = 1;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++; $display("FAIL rt_M_hazard: stall=%b expected 1", stall);
    end
    tnew_M = 1;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL rt_M_equal_t: stall=%b expected 0", stall);
    end
    for (int k = 0; k < 60; k++) begin
      rs_D = 5'($urandom_range(0, 3)); rt_D = 5'($urandom_range(0, 3));
      a3_E = 5'($urandom_range(0, 3)); a3_M = 5'($urandom_range(0, 3));
      tuse_rs = 2'($urandom); tuse_rt = 2'($urandom);
      tnew_E = 2'($urandom); tnew_M = 2'($urandom);
      #1;
      checks++;
      if (stall !== model_stall() || e_flush !== model_stall()) begin
        errors++;
        $display("FAIL data_rand: rs=%0d rt=%0d a3E=%0d a3M=%0d tuse=%0d/%0d tnew=%0d/%0d stall=%b expected %b",
                 rs_D, rt_D, a3_E, a3_M, tuse_rs, tuse_rt, tnew_E, tnew_M, stall, model_stall());
      end
    end
  endtask

  task automatic test_md_mult();
    do_reset();
    md_use_D = 1'b1;
    for (int k = 0; k <= 7; k++) begin
      md_start_E  = (k == 0);
      md_is_div_E = 1'b0;
      #3;
      checks++;
      if (stall !== (k <= 5)) begin
        errors++; $display("FAIL mult_stall c%0d: stall=%b expected %b", k, stall, k <= 5);
      end
      tick();
    end
  endtask

  task automatic test_md_div_reload();
    do_reset();
    md_is_div_E = 1'b1;
    for (int k = 0; k <= 12; k++) begin
      md_start_E = (k == 0 || k == 3);
      #3;
      checks++;
      if (md_busy !== (k <= 10) || stall !== 1'b0) begin
        errors++;
        $display("FAIL div_reload c%0d: md_busy=%b stall=%b expected %b 0", k, md_busy, stall, k <= 10);
      end
      tick();
    end
  endtask

  task automatic test_md_reset();
    do_reset();
    md_is_div_E = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      md_start_E = (k == 0);
      reset      = (k == 4);
      #3;
      checks++;
      if (md_busy !== (k <= 4)) begin
        errors++; $display("FAIL md_reset c%0d: md_busy=%b expected %b", k, md_busy, k <= 4);
      end
      tick();
    end
    reset = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 400; k++) begin
      reset       = ($urandom_range(0, 39) == 0);
      rs_D        = 5'($urandom_range(0, 4)); rt_D = 5'($urandom_range(0, 4));
      a3_E        = 5'($urandom_range(0, 4)); a3_M = 5'($urandom_range(0, 4));
      tuse_rs     = 2'($urandom); tuse_rt = 2'($urandom);
      tnew_E      = 2'($urandom); tnew_M = 2'($urandom);
      md_start_E  = ($urandom_range(0, 5) == 0);
      md_is_div_E = 1'($urandom);
      md_use_D    = 1'($urandom);
      #3;
      checks++;
      if (stall !== model_stall() || pc_en !== !model_stall() || d_en !== !model_stall() ||
          e_flush !== model_stall() || md_busy !== model_busy()) begin
        errors++;
        $display("FAIL random c%0d: stall=%b pc_en=%b d_en=%b e_flush=%b md_busy=%b expected stall=%b md_busy=%b",
                 k, stall, pc_en, d_en, e_flush, md_busy, model_stall(), model_busy());
      end
`ifdef STALL_PERF_CNT_EN
      checks++;
      if (stall_cycles !== perf_cnt) begin
        errors++; $display("FAIL perf_rand c%0d: stall_cycles=%0d expected %0d", k, stall_cycles, perf_cnt);
      end
`endif
      tick();
    end
    reset = 1'b0;
  endtask

`ifdef STALL_PERF_CNT_EN
  task automatic test_perf();
    do_reset();
    rs_D = 8; tuse_rs = 0; a3_E = 8; tnew_E = 1;
    repeat (6) tick();
    clear_inputs();
    tick();
    #3;
    checks++;
    if (stall_cycles !== 32'd6) begin
      errors++; $display("FAIL perf_six: stall_cycles=%0d expected 6", stall_cycles);
    end
  endtask
`endif

  initial begin
    clear_inputs();
    reset = 1'b1;
    test_reset();
    test_data_hazard();
    test_md_mult();
    test_md_div_reload();
    test_md_reset();
    test_random();
`ifdef STALL_PERF_CNT_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
